phase_timer: RTL and testbench

- Consumer end of the divided 1 Hz clock.
- Synchronises clk_1Hz into the 100 MHz domain and turns each rising edge into a single-cycle tick.
- Uses the tick to run a loadable seconds countdown for the traffic-light FSM. Supports pedestrian-priority shortening and a pause (hold) input.
- Reports remaining seconds, a busy flag and a one-cycle done pulse.

---
 rtl/phase_timer_pkg.sv | 20 ++
 rtl/edge_sync.sv | 31 +++
 rtl/phase_timer.sv | 83 ++++++++
 tb/tb_phase_timer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_timer_pkg.sv
// Shared types and constants for the phase countdown timer and its traffic-light users.
package phase_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } timer_state_t;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SHORT_SEC   = 5;
  localparam int DEF_SYNC_STAGES = 2;

  // Phase lengths the traffic-light FSM loads into duration.
  localparam logic [DEF_CNT_W-1:0] GREEN_SEC  = 8'd30;
  localparam logic [DEF_CNT_W-1:0] YELLOW_SEC = 8'd4;
  localparam logic [DEF_CNT_W-1:0] RED_SEC    = 8'd25;
  localparam logic [DEF_CNT_W-1:0] WALK_SEC   = 8'd12;

endpackage

// File: rtl/edge_sync.sv
// Synchronises an asynchronous level and emits a registered one-cycle pulse per rising edge.
// Levels already high when reset releases are absorbed until the chain has settled.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic [STAGES-1:0] sync;
  logic              hist;
  logic [STAGES:0]   armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      hist  <= 1'b0;
      armed <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], async_in};
      hist  <= sync[STAGES-1];
      armed <= {armed[STAGES-1:0], 1'b1};
      // Edges are only trusted once hist reflects a level sampled after reset.
      pulse <= armed[STAGES] & sync[STAGES-1] & ~hist;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Loadable seconds countdown driven by the synchronised 1 Hz tick, with pedestrian shorten and hold.
// Priority inside a running phase is load > shorten > tick; done pulses one cycle after expiry.
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SHORT_SEC   = DEF_SHORT_SEC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             clk_1Hz,
  input  logic             load,
  input  logic [CNT_W-1:0] duration,
  input  logic             shorten,
  input  logic             hold,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             tick_1s
);

  localparam logic [CNT_W-1:0] SHORT_V = CNT_W'(SHORT_SEC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  timer_state_t state;

  edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk_100MHz),
    .reset    (reset),
    .async_in (clk_1Hz),
    .pulse    (tick_1s)
  );

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      if (load) begin
        // A load restarts the phase from any state; zero expires immediately.
        if (duration != '0) begin
          state     <= RUN;
          remaining <= duration;
          busy      <= 1'b1;
        end else begin
          state     <= EXPIRE;
          remaining <= '0;
          done      <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            busy <= 1'b1;
            if (shorten) begin
              if (remaining > SHORT_V) remaining <= SHORT_V;
              if (SHORT_V == '0) begin
                state <= EXPIRE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else if (tick_1s && !hold) begin
              if (remaining <= ONE) begin
                remaining <= '0;
                state     <= EXPIRE;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                remaining <= remaining - ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer: directed table, hand-aligned collisions, randomized model run.
module tb_phase_timer;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic       clk_1Hz    = 1'b0;
  logic       load       = 1'b0;
  logic [7:0] duration   = 8'd0;
  logic       shorten    = 1'b0;
  logic       hold       = 1'b0;
  logic [7:0] remaining;
  logic       busy;
  logic       done;
  logic       tick_1s;

  int tests  = 0;
  int failed = 0;

  phase_timer dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clk_1Hz    (clk_1Hz),
    .load       (load),
    .duration   (duration),
    .shorten    (shorten),
    .hold       (hold),
    .remaining  (remaining),
    .busy       (busy),
    .done       (done),
    .tick_1s    (tick_1s)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  localparam int OP_NOP = 0, OP_LOAD = 1, OP_SHORT = 2, OP_TICK = 3;

  typedef struct {
    int op;
    int arg;
    bit hv;
    int rem;
    bit bsy;
  } vec_t;

  function automatic vec_t mk(int op, int arg, bit hv, int rem, bit bsy);
    vec_t v;
    v.op = op; v.arg = arg; v.hv = hv; v.rem = rem; v.bsy = bsy;
    return v;
  endfunction

  // One full 20-cycle clk_1Hz period; the single tick lands inside it.
  task automatic full_tick(input bit hv);
    hold = hv;
    for (int i = 0; i < 20; i++) begin
      clk_1Hz = (i < 10);
      @(negedge clk_100MHz);
    end
    hold = 1'b0;
  endtask

  // Random-run reference model state.
  int   m_rem;
  bit   m_run, m_done, m_tick;
  logic s_hist [0:3100];

  initial begin
    vec_t tbl[$];
    int   k, hp, ntick;
    bit   c1, ld, sh, hd, t_used;
    int   dur;

    // Reset state
    repeat (3) @(negedge clk_100MHz);
    chk("rst_remaining", remaining, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick_1s, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk_100MHz);

    // Tick generation: pulse exactly 3 cycles after each rise, nothing on falls
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_100MHz);
        chk("tick_shape", tick_1s, (i == 3));
        clk_1Hz = (i < 10);
      end
    end
    @(negedge clk_100MHz);
    chk("tick_after", tick_1s, 0);

    // Directed table
    tbl.push_back(mk(OP_LOAD, 3, 0, 3, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 2, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 1, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 0, 0));
    tbl.push_back(mk(OP_LOAD, 20, 0, 20, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 19, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 18, 1));
    tbl.push_back(mk(OP_SHORT, 0, 0, 5, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 4, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 3, 1));
    tbl.push_back(mk(OP_SHORT, 0, 0, 3, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 2, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 1, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 0, 0));
    tbl.push_back(mk(OP_LOAD, 4, 0, 4, 1));
    tbl.push_back(mk(OP_TICK, 0, 1, 4, 1));
    tbl.push_back(mk(OP_TICK, 0, 1, 4, 1));
    tbl.push_back(mk(OP_TICK, 0, 1, 4, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 3, 1));
    tbl.push_back(mk(OP_TICK, 0, 0, 2, 1));
    tbl.push_back(mk(OP_LOAD, 0, 0, 0, 0));
    tbl.push_back(mk(OP_NOP, 0, 0, 0, 0));
    tbl.push_back(mk(OP_SHORT, 0, 0, 0, 0));
    tbl.push_back(mk(OP_TICK, 0, 1, 0, 0));

    foreach (tbl[n]) begin
      case (tbl[n].op)
        OP_LOAD: begin
          load = 1'b1; duration = 8'(tbl[n].arg);
          @(negedge clk_100MHz);
          load = 1'b0;
        end
        OP_SHORT: begin
          shorten = 1'b1;
          @(negedge clk_100MHz);
          shorten = 1'b0;
        end
        OP_TICK: full_tick(tbl[n].hv);
        default: @(negedge clk_100MHz);
      endcase
      chk($sformatf("tbl%0d_remaining", n), remaining, tbl[n].rem);
      chk($sformatf("tbl%0d_busy", n), busy, tbl[n].bsy);
    end

    // Done latency: done the cycle after the 1->0 tick, for one cycle only
    load = 1'b1; duration = 8'd2;
    @(negedge clk_100MHz);
    load = 1'b0;
    full_tick(1'b0);
    clk_1Hz = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    chk("exp_tick", tick_1s, 1);
    chk("exp_pre_rem", remaining, 1);
    chk("exp_pre_done", done, 0);
    @(negedge clk_100MHz);
    chk("exp_rem", remaining, 0);
    chk("exp_done", done, 1);
    chk("exp_busy", busy, 0);
    @(negedge clk_100MHz);
    chk("exp_done_once", done, 0);
    clk_1Hz = 1'b0;
    repeat (12) @(negedge clk_100MHz);

    // Load 0 in IDLE, then load 2 in the EXPIRE cycle
    load = 1'b1; duration = 8'd0;
    @(negedge clk_100MHz);
    chk("z_done", done, 1);
    chk("z_rem", remaining, 0);
    chk("z_busy", busy, 0);
    duration = 8'd2;
    @(negedge clk_100MHz);
    load = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_rem", remaining, 2);
    chk("b2b_done", done, 0);

    // Load coincident with tick: tick dropped
    load = 1'b1; duration = 8'd15;
    @(negedge clk_100MHz);
    load = 1'b0;
    clk_1Hz = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    chk("ld_col_tick", tick_1s, 1);
    load = 1'b1; duration = 8'd9;
    @(negedge clk_100MHz);
    load = 1'b0;
    chk("ld_col_rem", remaining, 9);
    @(negedge clk_100MHz);
    chk("ld_col_rem2", remaining, 9);
    clk_1Hz = 1'b0;
    repeat (12) @(negedge clk_100MHz);

    // Shorten coincident with tick at 12: clamps to 5, tick dropped
    load = 1'b1; duration = 8'd12;
    @(negedge clk_100MHz);
    load = 1'b0;
    clk_1Hz = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    chk("sh_col_tick", tick_1s, 1);
    shorten = 1'b1;
    @(negedge clk_100MHz);
    shorten = 1'b0;
    chk("sh_col_rem", remaining, 5);
    chk("sh_col_busy", busy, 1);
    clk_1Hz = 1'b0;
    repeat (12) @(negedge clk_100MHz);

    // Asynchronous reset mid-count
    #2 reset = 1'b1;
    #1;
    chk("arst_rem", remaining, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_tick", tick_1s, 0);

    // clk_1Hz already high at reset release: no tick until the next real rise
    clk_1Hz = 1'b1;
    @(negedge clk_100MHz);
    reset = 1'b0;
    ntick = 0;
    repeat (20) begin
      @(negedge clk_100MHz);
      if (tick_1s) ntick++;
      if (done) ntick++;
    end
    chk("hi_at_release_ticks", ntick, 0);
    clk_1Hz = 1'b0;
    repeat (6) @(negedge clk_100MHz);
    clk_1Hz = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    chk("rise_after_release", tick_1s, 1);
    clk_1Hz = 1'b0;
    repeat (6) @(negedge clk_100MHz);

    // Randomized run against a rule-level model
    reset = 1'b1;
    @(negedge clk_100MHz);
    reset = 1'b0;
    k = 0; hp = 5; c1 = 1'b0;
    m_rem = 0; m_run = 1'b0; m_done = 1'b0; m_tick = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      if (hp == 0) begin
        c1 = ~c1;
        hp = $urandom_range(2, 12);
      end else begin
        hp--;
      end
      ld  = ($urandom_range(0, 19) == 0);
      dur = $urandom_range(0, 12);
      sh  = ($urandom_range(0, 24) == 0);
      hd  = ($urandom_range(0, 3) == 0);
      clk_1Hz = c1; load = ld; duration = 8'(dur); shorten = sh; hold = hd;

      t_used = m_tick;
      m_done = 1'b0;
      if (ld) begin
        if (dur > 0) begin
          m_run = 1'b1; m_rem = dur;
        end else begin
          m_run = 1'b0; m_rem = 0; m_done = 1'b1;
        end
      end else if (m_run) begin
        if (sh) begin
          if (m_rem > 5) m_rem = 5;
        end else if (t_used && !hd) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_run = 1'b0; m_done = 1'b1;
          end
        end
      end
      k++;
      s_hist[k] = c1;
      m_tick = (k >= 4) ? (s_hist[k-2] & ~s_hist[k-3]) : 1'b0;

      @(negedge clk_100MHz);
      chk("rnd_tick", tick_1s, m_tick);
      chk("rnd_remaining", remaining, m_rem);
      chk("rnd_busy", busy, m_run);
      chk("rnd_done", done, m_done);
    end
    load = 1'b0; shorten = 1'b0; hold = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
